// File: rtl/frame_proto_pkg.sv
// Shared framing constants and FSM encoding for the byte-stream frame parser.
// Frame layout: [H][L][source][len_h][len_l][data...][checksum].
package frame_proto_pkg;

  localparam logic [7:0] FRAME_HDR_H = 8'hAA;
  localparam logic [7:0] FRAME_HDR_L = 8'h44;
  localparam int         CSUM_W      = 8;

  typedef enum logic [2:0] {
    ST_HUNT_H1   = 3'd0,
    ST_HUNT_H2   = 3'd1,
    ST_GET_SRC   = 3'd2,
    ST_GET_LEN_H = 3'd3,
    ST_GET_LEN_L = 3'd4,
    ST_GET_DATA  = 3'd5,
    ST_GET_CSUM  = 3'd6,
    ST_DELIVER   = 3'd7
  } state_e;

  function automatic logic [CSUM_W-1:0] csum_add(input logic [CSUM_W-1:0] sum,
                                                 input logic [7:0]        b);
    return sum + CSUM_W'(b);
  endfunction

endpackage

// File: rtl/frame_payload_buf.sv
// Small register-file byte buffer: synchronous write, combinational read.
// Reads outside DEPTH return zero so callers may look one slot ahead.
module frame_payload_buf #(
  parameter int DEPTH = 16,
  parameter int W     = 8,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data
);

  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  assign rd_data = (int'(rd_addr) < DEPTH) ? mem_q[rd_addr] : '0;

endmodule

// File: rtl/frame_unpacker.sv
// Parses [H][L][src][len_h][len_l][data][csum] frames, buffers the payload and
// replays it as a valid/ready stream only after the checksum verifies.
//
// state        | meaning
// HUNT_H1      | waiting for first header byte
// HUNT_H2      | first header seen, expecting second (repeated H stays here)
// GET_SRC      | next byte is the source id
// GET_LEN_H    | next byte is length high (must be zero)
// GET_LEN_L    | next byte is length low (1..MAX_PAYLOAD)
// GET_DATA     | storing payload bytes into the buffer
// GET_CSUM     | next byte is the checksum
// DELIVER      | replaying buffered payload, input stalled
module frame_unpacker
  import frame_proto_pkg::*;
#(
  parameter logic [7:0] FRAME_HEADER_H = FRAME_HDR_H,
  parameter logic [7:0] FRAME_HEADER_L = FRAME_HDR_L,
  parameter int         MAX_PAYLOAD    = 16,
  parameter int         TIMEOUT_CYCLES = 65535
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       out_req,
  output logic [7:0] out_data,
  output logic [7:0] out_source,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       frame_ok,
  output logic       csum_err,
  output logic       len_err,
  output logic       timeout_err,
  output logic [7:0] err_count
);

  localparam int          IDX_W      = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
  localparam logic [15:0] TIMEOUT_LD = 16'(TIMEOUT_CYCLES);
  localparam logic [7:0]  MAX_LEN    = 8'(MAX_PAYLOAD);

  state_e              state_q, state_d;
  logic [CSUM_W-1:0]   sum_q, sum_d;
  logic [7:0]          src_q, src_d;
  logic [7:0]          len_h_q, len_h_d;
  logic [7:0]          count_q, count_d;
  logic [7:0]          idx_q, idx_d;
  logic [15:0]         idle_q, idle_d;
  logic                out_req_q, out_req_d;
  logic                out_valid_q, out_valid_d;
  logic [7:0]          out_data_q, out_data_d;
  logic [7:0]          out_source_q, out_source_d;
  logic                frame_ok_q, frame_ok_d;
  logic                csum_err_q, csum_err_d;
  logic                len_err_q, len_err_d;
  logic                timeout_err_q, timeout_err_d;
  logic [7:0]          err_count_q, err_count_d;

  logic                accept;
  logic                timer_active;
  logic                timeout_hit;
  logic                err_evt;
  logic [7:0]          idx_next;
  logic                buf_wr_en;
  logic [IDX_W-1:0]    buf_wr_addr;
  logic [IDX_W-1:0]    buf_rd_addr;
  logic [7:0]          buf_rd_data;

  assign in_ready     = (state_q != ST_DELIVER);
  assign accept       = in_valid && in_ready;
  assign idx_next     = idx_q + 8'd1;
  assign timer_active = (state_q == ST_GET_SRC)   || (state_q == ST_GET_LEN_H) ||
                        (state_q == ST_GET_LEN_L) || (state_q == ST_GET_DATA)  ||
                        (state_q == ST_GET_CSUM);
  assign timeout_hit  = timer_active && !accept && (TIMEOUT_CYCLES != 0) &&
                        (idle_q == 16'd1);

  assign buf_wr_en   = accept && (state_q == ST_GET_DATA);
  assign buf_wr_addr = idx_q[IDX_W-1:0];
  // In DELIVER look one slot ahead so the next byte is ready when the current one is taken.
  assign buf_rd_addr = (state_q == ST_DELIVER) ? idx_next[IDX_W-1:0] : '0;

  frame_payload_buf #(
    .DEPTH (MAX_PAYLOAD),
    .W     (8),
    .AW    (IDX_W)
  ) u_buf (
    .clk     (clk),
    .wr_en   (buf_wr_en),
    .wr_addr (buf_wr_addr),
    .wr_data (in_data),
    .rd_addr (buf_rd_addr),
    .rd_data (buf_rd_data)
  );

  always_comb begin
    state_d       = state_q;
    sum_d         = sum_q;
    src_d         = src_q;
    len_h_d       = len_h_q;
    count_d       = count_q;
    idx_d         = idx_q;
    out_req_d     = out_req_q;
    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;
    out_source_d  = out_source_q;
    frame_ok_d    = 1'b0;
    csum_err_d    = 1'b0;
    len_err_d     = 1'b0;
    timeout_err_d = 1'b0;
    err_evt       = 1'b0;

    // Idle down-counter: reloaded on every byte and whenever the timer is inactive.
    idle_d = idle_q;
    if (accept || !timer_active) idle_d = TIMEOUT_LD;
    else if (idle_q != 16'd0)    idle_d = idle_q - 16'd1;

    if (timeout_hit) begin
      timeout_err_d = 1'b1;
      state_d       = ST_HUNT_H1;
    end else begin
      case (state_q)
        ST_HUNT_H1: begin
          if (accept && in_data == FRAME_HEADER_H) begin
            sum_d   = FRAME_HEADER_H;
            state_d = ST_HUNT_H2;
          end
        end
        ST_HUNT_H2: begin
          if (accept) begin
            if (in_data == FRAME_HEADER_L) begin
              sum_d   = csum_add(sum_q, in_data);
              state_d = ST_GET_SRC;
            end else if (in_data == FRAME_HEADER_H) begin
              sum_d = FRAME_HEADER_H;
            end else begin
              state_d = ST_HUNT_H1;
            end
          end
        end
        ST_GET_SRC: begin
          if (accept) begin
            src_d   = in_data;
            sum_d   = csum_add(sum_q, in_data);
            state_d = ST_GET_LEN_H;
          end
        end
        ST_GET_LEN_H: begin
          if (accept) begin
            len_h_d = in_data;
            sum_d   = csum_add(sum_q, in_data);
            state_d = ST_GET_LEN_L;
          end
        end
        ST_GET_LEN_L: begin
          if (accept) begin
            if (len_h_q != 8'd0 || in_data == 8'd0 || in_data > MAX_LEN) begin
              len_err_d = 1'b1;
              state_d   = ST_HUNT_H1;
            end else begin
              count_d = in_data;
              idx_d   = 8'd0;
              sum_d   = csum_add(sum_q, in_data);
              state_d = ST_GET_DATA;
            end
          end
        end
        ST_GET_DATA: begin
          if (accept) begin
            sum_d = csum_add(sum_q, in_data);
            if (idx_next == count_q) state_d = ST_GET_CSUM;
            else                     idx_d   = idx_next;
          end
        end
        ST_GET_CSUM: begin
          if (accept) begin
            if (in_data == sum_q) begin
              frame_ok_d   = 1'b1;
              idx_d        = 8'd0;
              out_req_d    = 1'b1;
              out_valid_d  = 1'b1;
              out_data_d   = buf_rd_data;
              out_source_d = src_q;
              state_d      = ST_DELIVER;
            end else begin
              csum_err_d = 1'b1;
              state_d    = ST_HUNT_H1;
            end
          end
        end
        ST_DELIVER: begin
          if (out_valid_q && out_ready) begin
            if (idx_next == count_q) begin
              out_req_d    = 1'b0;
              out_valid_d  = 1'b0;
              out_data_d   = 8'd0;
              out_source_d = 8'd0;
              state_d      = ST_HUNT_H1;
            end else begin
              idx_d      = idx_next;
              out_data_d = buf_rd_data;
            end
          end
        end
        default: state_d = ST_HUNT_H1;
      endcase
    end

    err_evt     = csum_err_d || len_err_d || timeout_err_d;
    err_count_d = (err_evt && err_count_q != 8'hFF) ? err_count_q + 8'd1 : err_count_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_HUNT_H1;
      sum_q         <= '0;
      src_q         <= 8'd0;
      len_h_q       <= 8'd0;
      count_q       <= 8'd0;
      idx_q         <= 8'd0;
      idle_q        <= TIMEOUT_LD;
      out_req_q     <= 1'b0;
      out_valid_q   <= 1'b0;
      out_data_q    <= 8'd0;
      out_source_q  <= 8'd0;
      frame_ok_q    <= 1'b0;
      csum_err_q    <= 1'b0;
      len_err_q     <= 1'b0;
      timeout_err_q <= 1'b0;
      err_count_q   <= 8'd0;
    end else begin
      state_q       <= state_d;
      sum_q         <= sum_d;
      src_q         <= src_d;
      len_h_q       <= len_h_d;
      count_q       <= count_d;
      idx_q         <= idx_d;
      idle_q        <= idle_d;
      out_req_q     <= out_req_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_source_q  <= out_source_d;
      frame_ok_q    <= frame_ok_d;
      csum_err_q    <= csum_err_d;
      len_err_q     <= len_err_d;
      timeout_err_q <= timeout_err_d;
      err_count_q   <= err_count_d;
    end
  end

  assign out_req     = out_req_q;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_source  = out_source_q;
  assign frame_ok    = frame_ok_q;
  assign csum_err    = csum_err_q;
  assign len_err     = len_err_q;
  assign timeout_err = timeout_err_q;
  assign err_count   = err_count_q;

endmodule

// File: doc/frame_unpacker.md
Name: frame_unpacker

Overview:
- Receive-side counterpart of the upload packing stage: parses a byte stream framed as [0xAA][0x44][source][len_h][len_l][data...][checksum] and validates it.
- Buffers the payload until the checksum verifies, then replays it as a raw (req, data, source, valid/ready) stream.
- Sits between a byte receiver (UART/USB RX) and command handlers. Corrupt, oversize or stalled frames are dropped and flagged.

Parameters:
FRAME_HEADER_H, 8'hAA, first header byte
FRAME_HEADER_L, 8'h44, second header byte
MAX_PAYLOAD, 16, payload buffer depth in bytes (1..255)
TIMEOUT_CYCLES, 65535, max idle clocks between bytes inside a frame before abort (0 disables)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_data  in  8  incoming stream byte
in_valid  in  1  in_data valid
in_ready  out  1  unpacker accepts byte
out_req  out  1  high for the duration of one delivered frame
out_data  out  8  payload byte
out_source  out  8  source byte of delivered frame
out_valid  out  1  out_data valid
out_ready  in  1  consumer accepts byte
frame_ok  out  1  1-cycle pulse, frame passed checksum
csum_err  out  1  1-cycle pulse, checksum mismatch
len_err  out  1  1-cycle pulse, len_h!=0, len_l==0 or len_l>MAX_PAYLOAD
timeout_err  out  1  1-cycle pulse, inter-byte timeout abort
err_count  out  8  saturating count of all three error types

Behaviour:
- Reset: clk/rst_n as decided (asynchronous, active-low). State HUNT_H1. All outputs 0. err_count 0. Buffer contents don't-care. Reset mid-frame or mid-delivery discards everything.
- Byte accepted = in_valid && in_ready. in_ready = 1 in every state except DELIVER.
- Checksum: 8-bit sum, mod 256, of all bytes from header H through the last data byte.
- State transitions, on each accepted byte:
  - HUNT_H1: byte==H -> HUNT_H2, sum<=H. Otherwise stay.
  - HUNT_H2: byte==L -> GET_SRC. Byte==H -> stay in HUNT_H2 (resync on AA AA 44). Else -> HUNT_H1.
  - GET_SRC: latch source -> GET_LEN_H.
  - GET_LEN_H: latch -> GET_LEN_L.
  - GET_LEN_L: if len_h!=0, len_l==0 or len_l>MAX_PAYLOAD -> pulse len_err, -> HUNT_H1. Else latch count, wr_idx<=0 -> GET_DATA.
  - GET_DATA: buf[wr_idx]<=byte. After count bytes -> GET_CSUM.
  - GET_CSUM: byte==sum -> frame_ok pulse, rd_idx<=0 -> DELIVER. Else csum_err pulse -> HUNT_H1.
- The running sum accumulates on every accepted byte from H through the last data byte.
- DELIVER:
  - out_req=1, out_valid=1, out_source=latched source, out_data=buf[rd_idx], all registered.
  - First byte valid on the cycle after the checksum byte is accepted.
  - Data and valid hold while out_ready=0.
  - On out_valid&&out_ready: rd_idx++. After the last byte is accepted, out_req and out_valid drop the next cycle and state -> HUNT_H1.
  - Throughput is 1 byte/clk when out_ready=1.
- Timeout: in GET_SRC..GET_CSUM, an idle counter resets on every accepted byte and increments otherwise. Reaching TIMEOUT_CYCLES -> timeout_err pulse, -> HUNT_H1. The counter is not active in the HUNT states or DELIVER.
- err_count increments on any error pulse and saturates at 255. Error pulses are mutually exclusive per cycle.
- A byte that matches H inside payload or header fields is treated as data; no mid-frame resync.

Decomposition:
- Shared package (frame_proto_pkg): header constants, state encoding localparams, checksum-width constant.
- Sub-module frame_payload_buf: MAX_PAYLOAD x 8 register file, synchronous write, combinational read by index. It is reused by other buffering stages.

Test Plan:
- Good frame: AA 44 01 00 02 11 22 24 -> frame_ok pulse; out_source=01; out_data 11 then 22 on consecutive cycles with out_ready=1; out_req drops after 22.
- Bad checksum: AA 44 01 00 02 11 22 25 -> csum_err pulse; no out_req; err_count=1. A following good frame is delivered.
- Resync: 00 AA AA 44 01 00 02 11 22 24 -> delivered as the good frame. Also 55 AA 12 AA 44 ... -> hunts correctly.
- Length errors: AA 44 01 00 11 and AA 44 01 01 02 and AA 44 01 00 00 -> three len_err pulses; err_count=3; the next valid 16-byte frame (len_l=0x10) is delivered intact.
- Backpressure: during delivery of a 4-byte frame, out_ready=0 for 3 cycles on byte 2 -> out_data/out_valid stable; in_ready=0 throughout DELIVER; no bytes lost or duplicated.
- Timeout/reset: with TIMEOUT_CYCLES=8, send AA 44 01 then idle 8 cycles -> timeout_err; a subsequent frame decodes. Assert rst_n mid-GET_DATA -> all outputs 0, err_count 0, HUNT_H1.
